// File: rtl/anomaly_channel_scheduler.sv
// anomaly_channel_scheduler
//   Time-shares one isolation-tree evaluation engine among NUM_CH sensor
//   FIFOs. A round-robin arbiter picks the next non-empty FIFO. The FSM
//   pops one sample, hands it to the engine with a start/done handshake and
//   bounds the wait with a timeout. It then reports a tagged result pulse
//   and updates the per-channel sticky flags and a saturating anomaly count.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   enable            permits new grants (an in-flight evaluation finishes)
//   ch_empty/ch_data  per-channel FIFO status and data (data valid the
//                     cycle after ch_rd_en)
//   ch_rd_en          registered one-hot pop strobe
//   eng_start/eng_data  start pulse and sample to the engine
//   eng_done/eng_anomaly  engine completion strobe and verdict
//   result_valid/result_ch/result_anomaly/timeout_err  result pulse
//   flag_clear        per-channel clear of the sticky flags
//   anomaly_flags     sticky per-channel anomaly flags
//   anomaly_count     saturating total anomaly count
module anomaly_channel_scheduler #(
   parameter  int NUM_CH  = 4,
   parameter  int DATA_W  = 8,
   parameter  int TIMEOUT = 64,
   localparam int CH_W    = $clog2(NUM_CH),
   localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [NUM_CH-1:0]        ch_empty,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [NUM_CH-1:0]        ch_rd_en,
   output logic                     eng_start,
   output logic [DATA_W-1:0]        eng_data,
   input  logic                     eng_done,
   input  logic                     eng_anomaly,
   output logic                     result_valid,
   output logic [CH_W-1:0]          result_ch,
   output logic                     result_anomaly,
   output logic                     timeout_err,
   input  logic [NUM_CH-1:0]        flag_clear,
   output logic [NUM_CH-1:0]        anomaly_flags,
   output logic [15:0]              anomaly_count
);

   typedef enum logic [2:0] {IDLE, POP, LATCH, ISSUE, WAIT, REPORT} state_t;

   state_t           state;
   logic [CH_W-1:0]  ptr;        // last channel served
   logic [CH_W-1:0]  grant;
   logic [CNT_W-1:0] cnt;        // WAIT cycles elapsed
   logic [CH_W-1:0]  next_grant;
   logic             any_req;

   function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base,
                                                input int off);
      int s;
      s = (int'(base) + off) % NUM_CH;
      return CH_W'(s);
   endfunction

   // Search ptr+1, ptr+2, ... ptr+NUM_CH. Scanning from the far end lets the
   // nearest non-empty channel overwrite the others, so the channel just
   // served (offset NUM_CH) ranks last.
   always_comb begin
      next_grant = ptr;
      any_req    = 1'b0;
      for (int i = NUM_CH; i >= 1; i--) begin
         if (!ch_empty[wrap_idx(ptr, i)]) begin
            next_grant = wrap_idx(ptr, i);
            any_req    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         ptr            <= CH_W'(NUM_CH - 1);
         grant          <= '0;
         cnt            <= '0;
         ch_rd_en       <= '0;
         eng_start      <= 1'b0;
         eng_data       <= '0;
         result_valid   <= 1'b0;
         result_ch      <= '0;
         result_anomaly <= 1'b0;
         timeout_err    <= 1'b0;
         anomaly_flags  <= '0;
         anomaly_count  <= '0;
      end else begin
         // Pulses default low; clears apply every cycle and a set later in
         // this block overrides the clear on the same bit.
         ch_rd_en      <= '0;
         eng_start     <= 1'b0;
         result_valid  <= 1'b0;
         timeout_err   <= 1'b0;
         anomaly_flags <= anomaly_flags & ~flag_clear;

         case (state)
            IDLE: begin
               if (enable && any_req) begin
                  grant    <= next_grant;
                  ch_rd_en <= NUM_CH'(1) << next_grant;
                  state    <= POP;
               end
            end
            POP: state <= LATCH;
            LATCH: begin
               // FIFO data is valid now; eng_data doubles as the sample
               // register and stays put until the next grant.
               eng_data  <= ch_data[int'(grant)*DATA_W +: DATA_W];
               eng_start <= 1'b1;
               state     <= ISSUE;
            end
            ISSUE: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               cnt <= cnt + CNT_W'(1);
               // done is checked first so it wins over a same-cycle timeout
               if (eng_done) begin
                  result_valid   <= 1'b1;
                  result_ch      <= grant;
                  result_anomaly <= eng_anomaly;
                  state          <= REPORT;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  result_valid   <= 1'b1;
                  result_ch      <= grant;
                  result_anomaly <= 1'b0;
                  timeout_err    <= 1'b1;
                  state          <= REPORT;
               end
            end
            REPORT: begin
               ptr            <= grant;
               result_anomaly <= 1'b0;
               if (result_anomaly) begin
                  anomaly_flags[grant] <= 1'b1;
                  if (anomaly_count != 16'hFFFF)
                     anomaly_count <= anomaly_count + 16'd1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_anomaly_channel_scheduler.sv
// Testbench for anomaly_channel_scheduler: table-driven single transactions,
// a continuous round-robin run, flag-clear races, reset and enable cases.
// A scoreboard queue holds the expected grant/sample/result per transaction.
module tb_anomaly_channel_scheduler;
   localparam int NUM_CH  = 4;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [3:0]  ch_empty;
   logic [31:0] ch_data;
   logic [3:0]  ch_rd_en;
   logic        eng_start;
   logic [7:0]  eng_data;
   logic        eng_done;
   logic        eng_anomaly;
   logic        result_valid;
   logic [1:0]  result_ch;
   logic        result_anomaly;
   logic        timeout_err;
   logic [3:0]  flag_clear;
   logic [3:0]  anomaly_flags;
   logic [15:0] anomaly_count;

   anomaly_channel_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .ch_empty(ch_empty), .ch_data(ch_data), .ch_rd_en(ch_rd_en),
      .eng_start(eng_start), .eng_data(eng_data),
      .eng_done(eng_done), .eng_anomaly(eng_anomaly),
      .result_valid(result_valid), .result_ch(result_ch),
      .result_anomaly(result_anomaly), .timeout_err(timeout_err),
      .flag_clear(flag_clear), .anomaly_flags(anomaly_flags),
      .anomaly_count(anomaly_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [1:0] ch;
      logic [7:0] data;
      logic       anom;
      logic       tmo;
      int         lat;   // cycles from the pop strobe to result_valid
   } exp_t;
   exp_t sb[$];

   task automatic push_exp(input logic [1:0] ch, input logic [7:0] data,
                           input logic anom, input logic tmo, input int eng_lat);
      exp_t e;
      e.ch = ch; e.data = data; e.anom = anom; e.tmo = tmo;
      e.lat = (eng_lat == 0) ? 3 + TIMEOUT : 3 + eng_lat;
      sb.push_back(e);
   endtask

   // ---------------- engine model ----------------
   // eng_lat = N: done N cycles after the start pulse; 0: never answers.
   int   eng_lat = 1;
   logic eng_verdict = 1'b0;
   initial begin
      int cd;
      cd = 0;
      eng_done = 1'b0;
      eng_anomaly = 1'b0;
      forever begin
         @(negedge clk);
         eng_done = 1'b0;
         eng_anomaly = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               eng_done = 1'b1;
               eng_anomaly = eng_verdict;
            end
         end
         if (eng_start) cd = eng_lat;
      end
   end

   // ---------------- monitor ----------------
   initial begin
      int cyc;
      int rd_cyc;
      exp_t e;
      cyc = 0;
      rd_cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (ch_rd_en != 4'b0) begin
            rd_cyc = cyc;
            if (sb.size() == 0) chk("unexpected_pop", 32'(ch_rd_en), 32'h0);
            else chk("ch_rd_en", 32'(ch_rd_en), 32'(4'b0001 << sb[0].ch));
         end
         if (eng_start) begin
            if (sb.size() == 0) chk("unexpected_start", 32'(eng_start), 32'h0);
            else begin
               chk("eng_data", 32'(eng_data), 32'(sb[0].data));
               chk("start_cycle", 32'(cyc - rd_cyc), 32'd2);
            end
         end
         if (result_valid) begin
            if (sb.size() == 0) chk("unexpected_result", 32'(result_valid), 32'h0);
            else begin
               e = sb.pop_front();
               chk("result_ch", 32'(result_ch), 32'(e.ch));
               chk("result_anomaly", 32'(result_anomaly), 32'(e.anom));
               chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
               chk("result_latency", 32'(cyc - rd_cyc), 32'(e.lat));
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic set_data(input logic [7:0] base);
      for (int i = 0; i < NUM_CH; i++) ch_data[i*8 +: 8] = base + 8'(i);
   endtask

   task automatic wait_result(output int n);
      bit ok;
      ok = 1'b0;
      n = 0;
      while (!ok && n < 200) begin
         @(negedge clk);
         n++;
         if (result_valid) ok = 1'b1;
      end
      if (!ok) chk("result_timeout", 32'h0, 32'h1);
   endtask

   function automatic logic [31:0] out_or();
      return 32'(|{ch_rd_en, eng_start, eng_data, result_valid, result_ch,
                  result_anomaly, timeout_err, anomaly_flags, anomaly_count});
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0]  empty;
      logic [7:0]  base;
      int          lat;
      logic        verdict;
      logic [1:0]  ch;
      logic        anom;
      logic        tmo;
      logic [3:0]  flags;
      logic [15:0] count;
   } vec_t;
   vec_t tbl[8];

   initial begin
      int n;
      int bad;
      // ptr starts at 3 here (after the continuous run below)
      tbl[0] = '{4'b1011, 8'h58, 3,       1'b1, 2'd2, 1'b1, 1'b0, 4'b0100, 16'd1};
      tbl[1] = '{4'b0000, 8'h10, 1,       1'b0, 2'd3, 1'b0, 1'b0, 4'b0100, 16'd1};
      tbl[2] = '{4'b0000, 8'h20, 2,       1'b1, 2'd0, 1'b1, 1'b0, 4'b0101, 16'd2};
      tbl[3] = '{4'b1100, 8'h30, 1,       1'b1, 2'd1, 1'b1, 1'b0, 4'b0111, 16'd3};
      tbl[4] = '{4'b0110, 8'h40, 4,       1'b0, 2'd3, 1'b0, 1'b0, 4'b0111, 16'd3};
      tbl[5] = '{4'b0111, 8'h50, 1,       1'b1, 2'd3, 1'b1, 1'b0, 4'b1111, 16'd4};
      tbl[6] = '{4'b1110, 8'h60, TIMEOUT, 1'b1, 2'd0, 1'b1, 1'b0, 4'b1111, 16'd5};
      tbl[7] = '{4'b1101, 8'h70, 0,       1'b1, 2'd1, 1'b0, 1'b1, 4'b1111, 16'd5};

      reset = 1'b1; enable = 1'b1; ch_empty = 4'hF; ch_data = '0; flag_clear = 4'h0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", out_or(), 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // continuous round robin: engine answers on the second WAIT cycle
      eng_lat = 2; eng_verdict = 1'b0; set_data(8'hA0);
      for (int k = 0; k < 8; k++) push_exp(2'(k % 4), 8'hA0 + 8'(k % 4), 1'b0, 1'b0, 2);
      ch_empty = 4'h0;
      for (int k = 0; k < 8; k++) begin
         wait_result(n);
         if (k > 0) chk("rr_period", 32'(n), 32'd7);
      end
      ch_empty = 4'hF;
      @(negedge clk);
      chk("rr_flags", 32'(anomaly_flags), 32'h0);

      // table: one transaction per vector
      for (int v = 0; v < 8; v++) begin
         @(negedge clk);
         eng_lat = tbl[v].lat; eng_verdict = tbl[v].verdict;
         set_data(tbl[v].base);
         push_exp(tbl[v].ch, tbl[v].base + 8'(tbl[v].ch), tbl[v].anom, tbl[v].tmo, tbl[v].lat);
         ch_empty = tbl[v].empty;
         @(negedge clk);
         ch_empty = 4'hF;
         wait_result(n);
         @(negedge clk);
         chk($sformatf("v%0d_flags", v), 32'(anomaly_flags), 32'(tbl[v].flags));
         chk($sformatf("v%0d_count", v), 32'(anomaly_count), 32'(tbl[v].count));
      end

      // clear everything
      flag_clear = 4'hF;
      @(negedge clk);
      flag_clear = 4'h0;
      chk("clear_all_flags", 32'(anomaly_flags), 32'h0);
      chk("clear_keeps_count", 32'(anomaly_count), 32'd5);

      // clear and set of flag 0 in the same REPORT cycle: set wins
      eng_lat = 1; eng_verdict = 1'b1; set_data(8'h80);
      push_exp(2'd0, 8'h80, 1'b1, 1'b0, 1);
      ch_empty = 4'b1110;
      @(negedge clk);
      ch_empty = 4'hF;
      wait_result(n);
      flag_clear = 4'b0001;
      @(negedge clk);
      flag_clear = 4'h0;
      chk("set_beats_clear", 32'(anomaly_flags), 32'b0001);
      chk("count_after_race", 32'(anomaly_count), 32'd6);
      @(negedge clk);
      flag_clear = 4'b0001;
      @(negedge clk);
      flag_clear = 4'h0;
      chk("later_clear", 32'(anomaly_flags), 32'h0);

      // reset while WAITing on a silent engine
      eng_lat = 0; set_data(8'h90);
      push_exp(2'd1, 8'h91, 1'b0, 1'b1, 0);
      ch_empty = 4'b1101;
      @(negedge clk);
      ch_empty = 4'hF;
      repeat (6) @(negedge clk);
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("reset_mid_wait", out_or(), 32'h0);
      reset = 1'b0;
      bad = 0;
      repeat (80) begin
         @(negedge clk);
         if (result_valid || ch_rd_en != 4'h0) bad++;
      end
      chk("idle_after_reset", 32'(bad), 32'd0);

      // enable low: no grants even with data waiting
      enable = 1'b0; ch_empty = 4'h0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (ch_rd_en != 4'h0) bad++;
      end
      chk("enable_low_no_pop", 32'(bad), 32'd0);

      // re-enable: reset restored priority to channel 0
      eng_lat = 1; eng_verdict = 1'b0; set_data(8'hC0);
      push_exp(2'd0, 8'hC0, 1'b0, 1'b0, 1);
      enable = 1'b1;
      @(negedge clk);
      ch_empty = 4'hF;
      wait_result(n);
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
